// File: rtl/serial_frame_rx_3bit_if.sv
// serial_frame_rx_3bit_if: bit strobe/serial input and received-word outputs of the 3-bit frame receiver
interface serial_frame_rx_3bit_if;
  logic       bit_en;
  logic       sdi;
  logic [2:0] dout;
  logic       dout_valid;
  logic       par_err;
  logic       frm_err;
  logic       busy;
  modport master(output bit_en, sdi, input dout, dout_valid, par_err, frm_err, busy);
  modport slave(input bit_en, sdi, output dout, dout_valid, par_err, frm_err, busy);
endinterface

// File: rtl/serial_frame_rx_3bit.sv
// serial_frame_rx_3bit: LSB-first 3-bit serial frame receiver with optional parity, framing check and break detection
module serial_frame_rx_3bit #(
  parameter bit PARITY_EN  = 1'b1,
  parameter bit ODD_PARITY = 1'b0
) (
  input logic                   clk,
  input logic                   rst,
  serial_frame_rx_3bit_if.slave s
);
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, BREAK} state_t;
  state_t     state;
  logic [1:0] cnt;
  logic [2:0] sh;
  logic       pbit;
  logic       pfail;
  assign pfail  = PARITY_EN && ((^{sh, pbit}) ^ ODD_PARITY);
  assign s.busy = state != IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 2'd0;
      sh           <= 3'b000;
      pbit         <= 1'b0;
      s.dout       <= 3'b000;
      s.dout_valid <= 1'b0;
      s.par_err    <= 1'b0;
      s.frm_err    <= 1'b0;
    end else begin
      s.dout_valid <= 1'b0;
      s.par_err    <= 1'b0;
      s.frm_err    <= 1'b0;
      if (s.bit_en)
        case (state)
          IDLE: if (!s.sdi) begin
            state <= DATA;
            cnt   <= 2'd0;
          end
          DATA: begin
            sh  <= {s.sdi, sh[2:1]};
            cnt <= cnt + 2'd1;
            if (cnt == 2'd2) state <= PARITY_EN ? PARITY : STOP;
          end
          PARITY: begin
            pbit  <= s.sdi;
            state <= STOP;
          end
          STOP: if (!s.sdi) begin
            s.frm_err <= 1'b1;
            state     <= BREAK;
          end else if (pfail) begin
            s.par_err <= 1'b1;
            state     <= IDLE;
          end else begin
            s.dout       <= sh;
            s.dout_valid <= 1'b1;
            state        <= IDLE;
          end
          BREAK: if (s.sdi) state <= IDLE;
          default: state <= IDLE;
        endcase
    end
endmodule
